// File: rtl/par_to_ser_pkg.sv
// Shared definitions for the parallel-to-serial converter: state encoding
// and the counter width helper used by the top and the bit divider.
package par_to_ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/par_to_ser_bit_tick.sv
// Bit-period divider: counts 0..DIV-1 while enabled and flags the last
// cycle of each bit period. A synchronous clear restarts the period.
module bit_tick
    import par_to_ser_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic r,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int                CNT_W    = cnt_width(DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("bit_tick: DIV must be >= 1");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_r;

    // Period counter: wraps at DIV-1 so it never overflows within a frame.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = en & (cnt_r == CNT_LAST);

endmodule

// File: rtl/par_to_ser.sv
// Parallel-to-serial converter: captures a W-bit word on a load handshake
// and shifts it out on sdo, holding each bit for DIV clocks. frame marks
// the data bits, done pulses for one cycle after the last bit.
module par_to_ser
    import par_to_ser_pkg::*;
#(
    parameter int W         = 4,
    parameter int DIV       = 2,
    parameter int MSB_FIRST = 0
) (
    input  logic         clk,
    input  logic         r,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic         ready,
    output logic         sdo,
    output logic         frame,
    output logic         done
);

    localparam int               BIT_W    = cnt_width(W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam int               OUT_IDX  = (MSB_FIRST != 0) ? (W - 1) : 0;

    generate
        if (W < 1) begin : g_bad_w
            $error("par_to_ser: W must be >= 1");
        end
    endgenerate

    state_t           state_r;
    state_t           next_state_s;
    logic [W-1:0]     shreg_r;
    logic [W-1:0]     shreg_next_s;
    logic [BIT_W-1:0] bit_cnt_r;
    logic [BIT_W-1:0] bit_cnt_next_s;
    logic             div_clr_s;
    logic             div_en_s;
    logic             tick_s;
    logic             ready_r;
    logic             sdo_r;
    logic             frame_r;
    logic             done_r;

    assign div_en_s = (state_r == ST_SHIFT);

    bit_tick #(
        .DIV (DIV)
    ) u_bit_tick (
        .clk  (clk),
        .r    (r),
        .en   (div_en_s),
        .clr  (div_clr_s),
        .tick (tick_s)
    );

    // Next-state, next shift-register contents and bit counter update.
    always_comb begin
        next_state_s   = state_r;
        shreg_next_s   = shreg_r;
        bit_cnt_next_s = bit_cnt_r;
        div_clr_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    shreg_next_s   = din;
                    bit_cnt_next_s = '0;
                    div_clr_s      = 1'b1;
                    next_state_s   = ST_SHIFT;
                end else begin
                    next_state_s   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (tick_s) begin
                    if (MSB_FIRST != 0) begin
                        shreg_next_s = shreg_r << 1;
                    end else begin
                        shreg_next_s = shreg_r >> 1;
                    end
                    if (bit_cnt_r == BIT_LAST) begin
                        // Last bit: leave the counter at zero rather than wrap.
                        bit_cnt_next_s = '0;
                        next_state_s   = ST_DONE;
                    end else begin
                        bit_cnt_next_s = bit_cnt_r + BIT_ONE;
                    end
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and counter registers.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_r   <= ST_IDLE;
            shreg_r   <= '0;
            bit_cnt_r <= '0;
        end else begin
            state_r   <= next_state_s;
            shreg_r   <= shreg_next_s;
            bit_cnt_r <= bit_cnt_next_s;
        end
    end

    // Outputs registered from the next state so they change with the state.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            ready_r <= 1'b1;
            sdo_r   <= 1'b1;
            frame_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= (next_state_s == ST_IDLE);
            frame_r <= (next_state_s == ST_SHIFT);
            done_r  <= (next_state_s == ST_DONE);
            sdo_r   <= (next_state_s == ST_SHIFT) ? shreg_next_s[OUT_IDX] : 1'b1;
        end
    end

    assign ready = ready_r;
    assign sdo   = sdo_r;
    assign frame = frame_r;
    assign done  = done_r;

endmodule

// File: tb/tb_par_to_ser.sv
// Directed self-checking bench for par_to_ser. Inputs change and outputs
// are sampled on the falling clock edge; "after E_k" means the falling edge
// that follows the k-th rising edge counted from the accepting edge E0.
module tb_par_to_ser;

    logic       clk = 1'b0;
    logic       r   = 1'b1;
    logic       load;
    logic [3:0] din;
    logic       ready, sdo, frame, done;
    logic       load_m;
    logic [3:0] din_m;
    logic       ready_m, sdo_m, frame_m, done_m;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    par_to_ser #(.W(4), .DIV(2), .MSB_FIRST(0)) dut (
        .clk   (clk),
        .r     (r),
        .load  (load),
        .din   (din),
        .ready (ready),
        .sdo   (sdo),
        .frame (frame),
        .done  (done)
    );

    par_to_ser #(.W(4), .DIV(1), .MSB_FIRST(1)) dut_msb (
        .clk   (clk),
        .r     (r),
        .load  (load_m),
        .din   (din_m),
        .ready (ready_m),
        .sdo   (sdo_m),
        .frame (frame_m),
        .done  (done_m)
    );

    task automatic test_reset();
        load   = 1'b0;
        din    = 4'h0;
        load_m = 1'b0;
        din_m  = 4'h0;
        #1 r = 1'b0;
        #1;
        checks++;
        if ({ready, sdo, frame, done} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_async actual rdy/sdo/frm/done=%b required=1100", {ready, sdo, frame, done});
        end
        checks++;
        if ({ready_m, sdo_m, frame_m, done_m} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_async_msb actual=%b required=1100", {ready_m, sdo_m, frame_m, done_m});
        end
        repeat (3) @(negedge clk);
        r = 1'b1;
        @(negedge clk);
        checks++;
        if ({ready, sdo, frame, done} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_release actual=%b required=1100", {ready, sdo, frame, done});
        end
    endtask

    // Serializes word w on the DIV=2 LSB-first instance and checks every cycle.
    task automatic run_lsb_frame(input logic [3:0] w, input string name);
        @(negedge clk);
        din  = w;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (frame !== 1'b1 || sdo !== w[k/2] || ready !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s_bit cyc=%0d actual frm=%b sdo=%b rdy=%b done=%b required frm=1 sdo=%b rdy=0 done=0",
                         name, k, frame, sdo, ready, done, w[k/2]);
            end
            @(negedge clk);
        end
        checks++;
        if ({ready, sdo, frame, done} !== 4'b0101) begin
            errors++;
            $display("FAIL %s_done actual rdy/sdo/frm/done=%b required=0101", name, {ready, sdo, frame, done});
        end
        @(negedge clk);
        checks++;
        if ({ready, sdo, frame, done} !== 4'b1100) begin
            errors++;
            $display("FAIL %s_ready actual rdy/sdo/frm/done=%b required=1100", name, {ready, sdo, frame, done});
        end
    endtask

    task automatic test_lsb_first();
        run_lsb_frame(4'b1011, "lsb");
    endtask

    task automatic test_msb_first();
        logic [3:0] w;
        w = 4'b1000;
        @(negedge clk);
        din_m  = w;
        load_m = 1'b1;
        @(negedge clk);
        load_m = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (frame_m !== 1'b1 || sdo_m !== w[3-k]) begin
                errors++;
                $display("FAIL msb_bit cyc=%0d actual frm=%b sdo=%b required frm=1 sdo=%b", k, frame_m, sdo_m, w[3-k]);
            end
            @(negedge clk);
        end
        checks++;
        if ({ready_m, sdo_m, frame_m, done_m} !== 4'b0101) begin
            errors++;
            $display("FAIL msb_done actual rdy/sdo/frm/done=%b required=0101", {ready_m, sdo_m, frame_m, done_m});
        end
        @(negedge clk);
        checks++;
        if (ready_m !== 1'b1 || frame_m !== 1'b0) begin
            errors++;
            $display("FAIL msb_ready actual rdy=%b frm=%b required rdy=1 frm=0", ready_m, frame_m);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w1, w2;
        logic       e_frm, e_sdo, e_rdy, e_done;
        w1 = 4'hA;
        w2 = 4'h5;
        @(negedge clk);
        din  = w1;
        load = 1'b1;
        @(negedge clk);
        din  = w2;
        for (int t = 0; t <= 20; t++) begin
            e_frm  = 1'b0;
            e_sdo  = 1'b1;
            e_rdy  = 1'b0;
            e_done = 1'b0;
            if (t <= 7) begin
                e_frm = 1'b1;
                e_sdo = w1[t/2];
            end else if (t == 8 || t == 18) begin
                e_done = 1'b1;
            end else if (t == 9 || t >= 19) begin
                e_rdy = 1'b1;
            end else begin
                e_frm = 1'b1;
                e_sdo = w2[(t-10)/2];
            end
            checks++;
            if ({ready, sdo, frame, done} !== {e_rdy, e_sdo, e_frm, e_done}) begin
                errors++;
                $display("FAIL b2b cyc=%0d actual rdy/sdo/frm/done=%b required=%b",
                         t, {ready, sdo, frame, done}, {e_rdy, e_sdo, e_frm, e_done});
            end
            if (t == 10) begin
                load = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        din  = 4'hC;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (frame !== 1'b1 || sdo !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre actual frm=%b sdo=%b required frm=1 sdo=1", frame, sdo);
        end
        #1 r = 1'b0;
        #1;
        checks++;
        if ({ready, sdo, frame, done} !== 4'b1100) begin
            errors++;
            $display("FAIL midrst_abort actual rdy/sdo/frm/done=%b required=1100", {ready, sdo, frame, done});
        end
        repeat (2) @(negedge clk);
        r = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || frame !== 1'b0) begin
                errors++;
                $display("FAIL midrst_nodone cyc=%0d actual done=%b frm=%b required done=0 frm=0", k, done, frame);
            end
        end
        run_lsb_frame(4'h3, "midrst_reload");
    endtask

    task automatic test_din_glitch();
        logic [3:0] w;
        w = 4'b0110;
        @(negedge clk);
        din  = w;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (frame !== 1'b1 || sdo !== w[k/2]) begin
                errors++;
                $display("FAIL glitch_bit cyc=%0d actual frm=%b sdo=%b required frm=1 sdo=%b", k, frame, sdo, w[k/2]);
            end
            din = ~din ^ 4'(k);
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || frame !== 1'b0) begin
            errors++;
            $display("FAIL glitch_done actual done=%b frm=%b required done=1 frm=0", done, frame);
        end
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_back_to_back();
        test_mid_reset();
        test_din_glitch();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
